axi_16bit_splitter: RTL and testbench
=====================================

Name: axi_16bit_splitter

Overview:
- AXI-Stream fork: the inverse of the two-input 8-bit adder join.
- Accepts one 16-bit input stream and splits each beat into two 8-bit output streams, each with its own independent valid/ready handshake.
  - Output 1 carries the low byte.
  - Output 2 carries the high byte.
- Each output has a small FIFO, so the two downstream consumers may drift apart by up to DEPTH beats without stalling each other.

Parameters:
- DATA_W, 8: width of each output stream. Input width is 2*DATA_W.
- DEPTH, 2: entries per output FIFO. Power of 2, at least 2.
- PTR_W, 1: log2(DEPTH). Must be consistent with DEPTH.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  reset, synchronous, active-high.
- s_axis_data  input  2*DATA_W  input beat; [DATA_W-1:0] goes to output 1, [2*DATA_W-1:DATA_W] goes to output 2.
- s_axis_valid  input  1  input beat valid.
- s_axis_ready  output  1  input beat accepted when high together with s_axis_valid.
- m_axis_data1  output  DATA_W  low-byte stream data (head of FIFO 1).
- m_axis_valid1  output  1  FIFO 1 not empty.
- m_axis_ready1  input  1  consumer 1 ready.
- m_axis_data2  output  DATA_W  high-byte stream data (head of FIFO 2).
- m_axis_valid2  output  1  FIFO 2 not empty.
- m_axis_ready2  input  1  consumer 2 ready.

Behaviour:
- Reset (rst=1 at posedge):
  - Both FIFOs empty: read/write pointers 0, counts 0.
  - Storage need not be cleared.
  - After reset: m_axis_valid1=0, m_axis_valid2=0, s_axis_ready=1.
  - rst asserted mid-operation discards all buffered beats, including partially drained ones. The next cycle behaves exactly as after power-up reset.
- FIFO structure:
  - Each FIFO has wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH) and count (PTR_W+1 bits, range 0..DEPTH).
  - full = (count==DEPTH); empty = (count==0).
- Input acceptance:
  - s_axis_ready = !full1 && !full2. Purely combinational from registered state.
  - No combinational path from m_axis_ready* to s_axis_ready.
  - push = s_axis_valid && s_axis_ready. A push writes both FIFOs in the same cycle, so every beat is split atomically.
  - No beat is ever written to only one FIFO.
- Output side:
  - m_axis_validN = !emptyN; m_axis_dataN = memN[rd_ptrN]. Both are registered-state driven, not combinational from the input.
  - popN = m_axis_validN && m_axis_readyN. Each FIFO pops independently.
- Latency: a beat accepted at edge k appears on both outputs in the cycle after edge k (1 cycle).
- Throughput: 1 beat/cycle sustained when both consumers hold ready=1.
- Count update per FIFO:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged, both pointers advance.
  - Neither: unchanged.
- Pointer wrap: wr_ptr and rd_ptr roll over from DEPTH-1 to 0.
- Full boundary: when either FIFO is full, s_axis_ready=0 that cycle even if that FIFO is popping this cycle. This is conservative and avoids the ready-from-ready path.
- Skew: one consumer may stall indefinitely. The other may drain at most DEPTH beats ahead, and input stalls once the stalled FIFO is full.
- Ordering: each output presents beats in exact input order. Beat n on output 1 and beat n on output 2 originate from the same input beat.
- AXI rule: m_axis_dataN is held stable while m_axis_validN=1 and m_axis_readyN=0.

Optional Feature:
- Macro: AXI_SPLITTER_TLAST_EN.
- Defined:
  - Adds ports s_axis_last (input, 1), m_axis_last1 (output, 1) and m_axis_last2 (output, 1).
  - The last bit is stored with the data in each FIFO entry and is presented with its beat on both outputs.
  - After reset, the head last bits read 0 while invalid.
- Not defined: these ports and storage are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then s_axis_valid=1 with data 0x12AB and both readys=1 -> the next cycle shows m_axis_data1=0xAB, m_axis_data2=0x12, both valid=1; popped the same cycle.
- Stream 0x0100, 0x0302, 0x0504, 0x0706 back-to-back with both readys=1 -> s_axis_ready stays 1; outputs show 00,02,04,06 and 01,03,05,07 on consecutive cycles.
- m_axis_ready2=0, m_axis_ready1=1, stream 4 beats (DEPTH=2) -> output 1 drains 2 beats; s_axis_ready=0 after 2 accepts; raising ready2 delivers the high bytes of beats 1,2 in order, then beats 3,4 are accepted.
- Both readys=0, 2 pushes -> s_axis_ready=0. Then ready1=1 only -> s_axis_ready remains 0 until output 2 pops once.
- Mid-stream rst=1 for 1 cycle with 2 beats buffered -> the next cycle has both valid=0 and s_axis_ready=1; beat 0xBEEF pushed after reset appears as 0xEF/0xBE with no stale data.
- With AXI_SPLITTER_TLAST_EN: push 0x1111 (last=0) then 0x2222 (last=1) -> m_axis_last1/2 are 0 then 1, aligned with their beats, even under skewed draining.

Source files
------------

// File: rtl/axi_16bit_splitter_if.sv
// Stream bundle for the 16-bit splitter: one wide input stream, two narrow output streams.
// Optional AXI_SPLITTER_TLAST_EN adds the last flags to every stream.
interface axi_16bit_splitter_if #(
  parameter int DATA_W = 8
);
  logic [2*DATA_W-1:0] s_axis_data;
  logic                s_axis_valid;
  logic                s_axis_ready;
  logic [DATA_W-1:0]   m_axis_data1;
  logic                m_axis_valid1;
  logic                m_axis_ready1;
  logic [DATA_W-1:0]   m_axis_data2;
  logic                m_axis_valid2;
  logic                m_axis_ready2;
`ifdef AXI_SPLITTER_TLAST_EN
  logic                s_axis_last;
  logic                m_axis_last1;
  logic                m_axis_last2;
`endif

  // Splitter side: accepts the wide stream, sources both narrow streams.
  modport slave (
    input  s_axis_data, s_axis_valid, m_axis_ready1, m_axis_ready2,
`ifdef AXI_SPLITTER_TLAST_EN
    input  s_axis_last,
    output m_axis_last1, m_axis_last2,
`endif
    output s_axis_ready, m_axis_data1, m_axis_valid1, m_axis_data2, m_axis_valid2
  );

  // Environment side: sources the wide stream, consumes both narrow streams.
  modport master (
    output s_axis_data, s_axis_valid, m_axis_ready1, m_axis_ready2,
`ifdef AXI_SPLITTER_TLAST_EN
    output s_axis_last,
    input  m_axis_last1, m_axis_last2,
`endif
    input  s_axis_ready, m_axis_data1, m_axis_valid1, m_axis_data2, m_axis_valid2
  );
endinterface

// File: rtl/axi_16bit_splitter.sv
// AXI-Stream fork: each 16-bit beat is split atomically into low/high byte FIFOs drained independently.
// Optional AXI_SPLITTER_TLAST_EN carries a last flag alongside every stored beat.
module axi_16bit_splitter #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2,
  parameter int PTR_W  = 1
) (
  input logic                   clk,
  input logic                   rst,
  axi_16bit_splitter_if.slave   bus
);

  localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem1 [DEPTH];
  logic [DATA_W-1:0] r_mem2 [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr1, r_rd_ptr1, r_wr_ptr2, r_rd_ptr2;
  logic [PTR_W:0]    r_cnt1, r_cnt2;

  logic w_full1, w_full2, w_empty1, w_empty2;
  logic w_s_ready, w_push, w_pop1, w_pop2;

  assign w_full1  = (r_cnt1 == CNT_FULL);
  assign w_full2  = (r_cnt2 == CNT_FULL);
  assign w_empty1 = (r_cnt1 == '0);
  assign w_empty2 = (r_cnt2 == '0);

  // Ready looks only at registered fill state; a full FIFO blocks input even while it pops.
  assign w_s_ready = !w_full1 && !w_full2;
  assign w_push    = bus.s_axis_valid && w_s_ready;
  assign w_pop1    = !w_empty1 && bus.m_axis_ready1;
  assign w_pop2    = !w_empty2 && bus.m_axis_ready2;

  assign bus.s_axis_ready  = w_s_ready;
  assign bus.m_axis_valid1 = !w_empty1;
  assign bus.m_axis_valid2 = !w_empty2;
  assign bus.m_axis_data1  = r_mem1[r_rd_ptr1];
  assign bus.m_axis_data2  = r_mem2[r_rd_ptr2];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem1[r_wr_ptr1] <= bus.s_axis_data[DATA_W-1:0];
      r_mem2[r_wr_ptr2] <= bus.s_axis_data[2*DATA_W-1:DATA_W];
    end
  end

`ifdef AXI_SPLITTER_TLAST_EN
  logic r_last1 [DEPTH];
  logic r_last2 [DEPTH];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_last1[r_wr_ptr1] <= bus.s_axis_last;
      r_last2[r_wr_ptr2] <= bus.s_axis_last;
    end
  end

  // Storage is not cleared on reset, so mask the head flag while the FIFO is empty.
  assign bus.m_axis_last1 = !w_empty1 && r_last1[r_rd_ptr1];
  assign bus.m_axis_last2 = !w_empty2 && r_last2[r_rd_ptr2];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr1 <= '0;
      r_rd_ptr1 <= '0;
      r_cnt1    <= '0;
      r_wr_ptr2 <= '0;
      r_rd_ptr2 <= '0;
      r_cnt2    <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr1 <= r_wr_ptr1 + 1'b1;
        r_wr_ptr2 <= r_wr_ptr2 + 1'b1;
      end
      if (w_pop1) r_rd_ptr1 <= r_rd_ptr1 + 1'b1;
      if (w_pop2) r_rd_ptr2 <= r_rd_ptr2 + 1'b1;

      case ({w_push, w_pop1})
        2'b10:   r_cnt1 <= r_cnt1 + 1'b1;
        2'b01:   r_cnt1 <= r_cnt1 - 1'b1;
        default: r_cnt1 <= r_cnt1;
      endcase

      case ({w_push, w_pop2})
        2'b10:   r_cnt2 <= r_cnt2 + 1'b1;
        2'b01:   r_cnt2 <= r_cnt2 - 1'b1;
        default: r_cnt2 <= r_cnt2;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_16bit_splitter.sv
// Bench for axi_16bit_splitter: queue model checked every cycle plus directed literal checks.
// Build with AXI_SPLITTER_TLAST_EN defined to also exercise the last-flag path.
module tb_axi_16bit_splitter;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;
  localparam int PTR_W  = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  axi_16bit_splitter_if #(.DATA_W(DATA_W)) bus ();

  axi_16bit_splitter #(.DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Model: two queues of bytes, each beat pushed to both or neither.
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic       ql1 [$];
  logic       ql2 [$];
  logic       model_live = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      q1.delete(); q2.delete(); ql1.delete(); ql2.delete();
      model_live = 1'b1;
    end else if (model_live) begin
      logic room, in_last;
      room = (q1.size() < DEPTH) && (q2.size() < DEPTH);
`ifdef AXI_SPLITTER_TLAST_EN
      in_last = bus.s_axis_last;
`else
      in_last = 1'b0;
`endif
      if (q1.size() != 0 && bus.m_axis_ready1) begin void'(q1.pop_front()); void'(ql1.pop_front()); end
      if (q2.size() != 0 && bus.m_axis_ready2) begin void'(q2.pop_front()); void'(ql2.pop_front()); end
      if (bus.s_axis_valid && room) begin
        q1.push_back(bus.s_axis_data[7:0]);
        q2.push_back(bus.s_axis_data[15:8]);
        ql1.push_back(in_last);
        ql2.push_back(in_last);
      end
    end
  end

  always @(negedge clk) begin
    if (model_live) begin
      check("valid1", 32'(bus.m_axis_valid1), 32'(q1.size() != 0));
      check("valid2", 32'(bus.m_axis_valid2), 32'(q2.size() != 0));
      check("s_ready", 32'(bus.s_axis_ready), 32'((q1.size() < DEPTH) && (q2.size() < DEPTH)));
      if (q1.size() != 0) check("data1", 32'(bus.m_axis_data1), 32'(q1[0]));
      if (q2.size() != 0) check("data2", 32'(bus.m_axis_data2), 32'(q2[0]));
`ifdef AXI_SPLITTER_TLAST_EN
      check("last1", 32'(bus.m_axis_last1), 32'((q1.size() != 0) ? ql1[0] : 1'b0));
      check("last2", 32'(bus.m_axis_last2), 32'((q2.size() != 0) ? ql2[0] : 1'b0));
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds the beat on the bus until the edge that accepts it; valid stays high on return.
  task automatic send_beat(input logic [15:0] d, input logic l);
    logic taken;
    taken = 1'b0;
    bus.s_axis_valid = 1'b1;
    bus.s_axis_data  = d;
`ifdef AXI_SPLITTER_TLAST_EN
    bus.s_axis_last  = l;
`else
    if (l) taken = 1'b0;
`endif
    for (int i = 0; i < 50 && !taken; i++) begin
      taken = bus.s_axis_ready;
      step();
    end
    checks++;
    if (!taken) begin
      errors++;
      $display("FAIL send_timeout: beat 0x%04h not accepted within 50 cycles", d);
    end
  endtask

  initial begin
    bus.s_axis_valid  = 1'b0;
    bus.s_axis_data   = '0;
    bus.m_axis_ready1 = 1'b1;
    bus.m_axis_ready2 = 1'b1;
`ifdef AXI_SPLITTER_TLAST_EN
    bus.s_axis_last   = 1'b0;
`endif
    step(); step();
    rst = 1'b0;
    check("rst_valid1", 32'(bus.m_axis_valid1), 32'h0);
    check("rst_valid2", 32'(bus.m_axis_valid2), 32'h0);
    check("rst_ready",  32'(bus.s_axis_ready),  32'h1);

    // Single beat, one-cycle latency.
    send_beat(16'h12AB, 1'b0);
    bus.s_axis_valid = 1'b0;
    check("t1_data1", 32'(bus.m_axis_data1), 32'hAB);
    check("t1_data2", 32'(bus.m_axis_data2), 32'h12);
    check("t1_valid", 32'({bus.m_axis_valid1, bus.m_axis_valid2}), 32'h3);
    step();
    check("t1_popped", 32'({bus.m_axis_valid1, bus.m_axis_valid2}), 32'h0);

    // Back-to-back stream at full rate.
    for (int i = 0; i < 4; i++) begin
      send_beat(16'((2*i+1) << 8 | (2*i)), 1'b0);
      check("t2_data1", 32'(bus.m_axis_data1), 32'(2*i));
      check("t2_data2", 32'(bus.m_axis_data2), 32'(2*i+1));
      check("t2_ready", 32'(bus.s_axis_ready), 32'h1);
    end
    bus.s_axis_valid = 1'b0;
    step();

    // Consumer 2 stalled: input blocks after DEPTH accepts.
    bus.m_axis_ready2 = 1'b0;
    send_beat(16'hA1B1, 1'b0);
    send_beat(16'hA2B2, 1'b0);
    check("t3_ready_low", 32'(bus.s_axis_ready), 32'h0);
    bus.s_axis_data = 16'hA3B3;
    step(); step();
    check("t3_ready_hold", 32'(bus.s_axis_ready), 32'h0);
    check("t3_out1_drained", 32'(bus.m_axis_valid1), 32'h0);
    check("t3_head2", 32'(bus.m_axis_data2), 32'hA1);
    bus.m_axis_ready2 = 1'b1;
    send_beat(16'hA3B3, 1'b0);
    send_beat(16'hA4B4, 1'b0);
    bus.s_axis_valid = 1'b0;
    repeat (3) step();

    // Both stalled, then only consumer 1 ready.
    bus.m_axis_ready1 = 1'b0;
    bus.m_axis_ready2 = 1'b0;
    send_beat(16'hC1D1, 1'b0);
    send_beat(16'hC2D2, 1'b0);
    bus.s_axis_valid = 1'b0;
    check("t4_full", 32'(bus.s_axis_ready), 32'h0);
    bus.m_axis_ready1 = 1'b1;
    step(); step();
    check("t4_still_full", 32'(bus.s_axis_ready), 32'h0);
    bus.m_axis_ready2 = 1'b1;
    step();
    bus.m_axis_ready2 = 1'b0;
    check("t4_freed", 32'(bus.s_axis_ready), 32'h1);
    check("t4_head2", 32'(bus.m_axis_data2), 32'hC2);
    bus.m_axis_ready2 = 1'b1;
    step(); step();

    // Reset with beats buffered.
    bus.m_axis_ready1 = 1'b0;
    bus.m_axis_ready2 = 1'b0;
    send_beat(16'h5566, 1'b0);
    send_beat(16'h7788, 1'b0);
    bus.s_axis_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_valid", 32'({bus.m_axis_valid1, bus.m_axis_valid2}), 32'h0);
    check("t5_ready", 32'(bus.s_axis_ready), 32'h1);
    bus.m_axis_ready1 = 1'b1;
    bus.m_axis_ready2 = 1'b1;
    send_beat(16'hBEEF, 1'b0);
    bus.s_axis_valid = 1'b0;
    check("t5_data1", 32'(bus.m_axis_data1), 32'hEF);
    check("t5_data2", 32'(bus.m_axis_data2), 32'hBE);
    step();

`ifdef AXI_SPLITTER_TLAST_EN
    // Last flags stay with their beats under skewed draining.
    bus.m_axis_ready2 = 1'b0;
    send_beat(16'h1111, 1'b0);
    check("t6_last1_a", 32'(bus.m_axis_last1), 32'h0);
    send_beat(16'h2222, 1'b1);
    bus.s_axis_valid = 1'b0;
    bus.s_axis_last  = 1'b0;
    check("t6_last1_b", 32'(bus.m_axis_last1), 32'h1);
    check("t6_last2_a", 32'(bus.m_axis_last2), 32'h0);
    bus.m_axis_ready2 = 1'b1;
    step();
    check("t6_last2_b", 32'(bus.m_axis_last2), 32'h1);
    check("t6_head2", 32'(bus.m_axis_data2), 32'h22);
    step();
`endif

    repeat (4) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
